// File: rtl/irq_ctrl.sv
// Interrupt aggregator: edge/level source latching, per-source enable, lowest-index priority vector.
// Optional macro IRQ_CTRL_SYNC_EN inserts a 2-flop synchronizer on every irq_in bit.
module irq_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] RESET_MODE = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [3:0]         irq_id
);

  localparam int N = NUM_IRQ;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_FORCE   = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;

  logic [N-1:0] irq_s;
  logic [N-1:0] irq_prev;
  logic [N-1:0] pending;
  logic [N-1:0] pending_nx;
  logic [N-1:0] enable;
  logic [N-1:0] mode;
  logic [N-1:0] active;
  logic [N-1:0] wdata;
  logic [N-1:0] edge_set;
  logic [N-1:0] edge_clr;
  logic [15:0]  read_mux;
  logic         wr;
  logic         wr_pending;
  logic         wr_enable;
  logic         wr_mode;
  logic         wr_force;
  logic         unused_wdata;

  assign wdata        = writedata[N-1:0];
  assign unused_wdata = ^writedata;

  assign wr         = chipselect && !write_n;
  assign wr_pending = wr && (address == ADDR_PENDING);
  assign wr_enable  = wr && (address == ADDR_ENABLE);
  assign wr_mode    = wr && (address == ADDR_MODE);
  assign wr_force   = wr && (address == ADDR_FORCE);

`ifdef IRQ_CTRL_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  function automatic logic [15:0] ext(input logic [N-1:0] v);
    ext = '0;
    ext[N-1:0] = v;
  endfunction

  // Set beats clear for edge sources; level sources simply track the sampled line.
  assign edge_set   = (irq_s & ~irq_prev) | (wr_force ? wdata : '0);
  assign edge_clr   = wr_pending ? wdata : '0;
  assign pending_nx = (mode & (edge_set | (pending & ~edge_clr))) | (~mode & irq_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
      enable   <= '0;
      mode     <= RESET_MODE[N-1:0];
    end else begin
      irq_prev <= irq_s;
      pending  <= pending_nx;
      if (wr_enable) enable <= wdata;
      if (wr_mode)   mode   <= wdata;
    end
  end

  assign active  = pending & enable;
  assign irq_out = |active;

  always_comb begin
    irq_id = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) irq_id = 4'(i);
    end
  end

  always_comb begin
    read_mux = 16'h0000;
    case (address)
      ADDR_PENDING: read_mux = ext(pending);
      ADDR_ENABLE:  read_mux = ext(enable);
      ADDR_MODE:    read_mux = ext(mode);
      ADDR_VECTOR:  read_mux = {irq_out, 11'b0, irq_id};
      ADDR_RAW:     read_mux = ext(irq_s);
      default:      read_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= 16'h0000;
    else       readdata <= read_mux;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: bit-level reference model, directed test-plan steps, then random traffic.
module tb_irq_ctrl;

  localparam int          NI    = 8;
  localparam logic [15:0] MASK  = 16'h00FF;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [15:0]   readdata;
  logic [NI-1:0] irq_in = '0;
  logic          irq_out;
  logic [3:0]    irq_id;

  int total = 0;
  int bad = 0;

  irq_ctrl #(.NUM_IRQ(NI), .RESET_MODE(16'h0000)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq_out(irq_out), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  bit [15:0] m_pend, m_en, m_mode, m_prev, m_s1, m_s2;
  bit [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pend = 0; m_en = 0; m_mode = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
  endtask

  function automatic bit [15:0] m_sampled();
`ifdef IRQ_CTRL_SYNC_EN
    return m_s2;
`else
    return 16'(irq_in);
`endif
  endfunction

  function automatic bit [15:0] m_vector();
    bit [15:0] act = m_pend & m_en;
    for (int i = 0; i < 16; i++)
      if (act[i]) return {1'b1, 11'b0, 4'(i)};
    return 16'h0000;
  endfunction

  function automatic bit [15:0] m_read(input bit [2:0] a);
    case (a)
      3'd0: return m_pend;
      3'd1: return m_en;
      3'd2: return m_mode;
      3'd3: return m_vector();
      3'd5: return m_sampled();
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_step();
    bit [15:0] s = m_sampled();
    bit [15:0] d = writedata & MASK;
    bit        wr = chipselect && !write_n;
    bit [15:0] np;
    if (chipselect && write_n) exp_q.push_back(m_read(address));
    for (int i = 0; i < NI; i++) begin
      if (m_mode[i]) begin
        if ((s[i] && !m_prev[i]) || (wr && address == 3'd4 && d[i])) np[i] = 1'b1;
        else if (wr && address == 3'd0 && d[i])                      np[i] = 1'b0;
        else                                                        np[i] = m_pend[i];
      end else begin
        np[i] = s[i];
      end
    end
    m_pend = np;
    if (wr && address == 3'd1) m_en = d;
    if (wr && address == 3'd2) m_mode = d;
    m_prev = s;
    m_s2 = m_s1;
    m_s1 = 16'(irq_in);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_reset();
        exp_q.delete();
      end else begin
        m_step();
      end
    end
  end

  // Monitor: interrupt outputs every cycle, read data whenever a read is outstanding.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("irq_out", 16'(irq_out), 16'(m_vector() >> 15));
        check("irq_id", 16'(irq_id), m_vector() & 16'h000F);
        if (exp_q.size() > 0) check("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  logic [15:0] rd;

  initial begin
    #1;
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq_out", 16'(irq_out), 16'h0000);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    bus_read(3'd2, rd); check("reset_mode", rd, 16'h0000);
    bus_read(3'd3, rd); check("reset_vector", rd, 16'h0000);

    // Edge source 0, single-cycle pulse, then W1C.
    bus_write(3'd2, 16'h0001);
    bus_write(3'd1, 16'h0001);
    irq_in = 8'h01; @(negedge clk); irq_in = 8'h00;
    repeat (LAT) @(negedge clk);
    check("edge0_irq_out", 16'(irq_out), 16'h0001);
    bus_read(3'd0, rd); check("edge0_pending", rd, 16'h0001);
    bus_read(3'd3, rd); check("edge0_vector", rd, 16'h8000);
    bus_write(3'd0, 16'h0001);
    check("edge0_cleared", 16'(irq_out), 16'h0000);

    // Level sources 2 and 5.
    bus_write(3'd2, 16'h0000);
    irq_in = 8'h24;
    bus_write(3'd1, 16'h0024);
    repeat (LAT) @(negedge clk);
    check("level_id2", 16'(irq_id), 16'h0002);
    bus_read(3'd3, rd); check("level_vec2", rd, 16'h8002);
    irq_in = 8'h20; @(negedge clk);
    repeat (LAT) @(negedge clk);
    check("level_id5", 16'(irq_id), 16'h0005);
    bus_read(3'd3, rd); check("level_vec5", rd, 16'h8005);
    bus_write(3'd0, 16'h0020);
    bus_read(3'd0, rd); check("level_w1c_ignored", rd, 16'h0020);
    irq_in = 8'h00;
    repeat (LAT + 1) @(negedge clk);

    // Edge source 3: clear and rising edge in the same cycle.
    bus_write(3'd2, 16'h0008);
    bus_write(3'd1, 16'h0008);
    irq_in = 8'h08;
    repeat (LAT) @(negedge clk);
    bus_write(3'd0, 16'h0008);
    bus_read(3'd0, rd); check("set_wins", rd, 16'h0008);
    bus_write(3'd0, 16'h0008);
    bus_read(3'd0, rd); check("clear_alone", rd, 16'h0000);
    irq_in = 8'h00;
    repeat (LAT + 1) @(negedge clk);

    // FORCE while disabled, then enable.
    bus_write(3'd1, 16'h0000);
    bus_write(3'd2, 16'h0010);
    bus_write(3'd4, 16'h0010);
    bus_read(3'd0, rd); check("force_pending", rd, 16'h0010);
    check("force_masked", 16'(irq_out), 16'h0000);
    bus_write(3'd1, 16'h0010);
    check("force_enabled", 16'(irq_out), 16'h0001);
    check("force_id", 16'(irq_id), 16'h0004);
    bus_read(3'd4, rd); check("force_reads0", rd, 16'h0000);
    bus_write(3'd1, 16'hFFFF);
    bus_read(3'd1, rd); check("upper_bits", rd, 16'h00FF);
    bus_write(3'd6, 16'hFFFF);
    bus_read(3'd6, rd); check("addr6", rd, 16'h0000);

    // Rising-edge latency, then asynchronous reset mid-pulse.
    bus_write(3'd1, 16'h0010);
    bus_write(3'd0, 16'h0010);
    irq_in = 8'h10;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check("latency_low", 16'(irq_out), 16'h0000);
    end
    @(negedge clk);
    check("latency_high", 16'(irq_out), 16'h0001);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    check("async_reset_irq", 16'(irq_out), 16'h0000);
    check("async_reset_rd", readdata, 16'h0000);
    @(negedge clk); irq_in = 8'h00;
    @(negedge clk); reset = 1'b0;
    bus_read(3'd0, rd); check("reset_pending", rd, 16'h0000);
    bus_read(3'd1, rd); check("reset_enable", rd, 16'h0000);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = NI'($urandom);
      case ($urandom_range(0, 2))
        0: @(negedge clk);
        1: bus_write(3'($urandom_range(0, 7)), 16'($urandom));
        default: bus_read(3'($urandom_range(0, 7)), rd);
      endcase
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
